// File: rtl/cci_mpf_prim_victim_select.sv
// Victim way selection for one set-associative lookup at a time: prefers an
// eligible empty way, otherwise consults the replacement policy and rotates past locked ways.
module cci_mpf_prim_victim_select #(
  parameter int N_WAYS    = 4,
  parameter int N_ENTRIES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          reqValid,
  input  logic [$clog2(N_ENTRIES)-1:0]  reqIdx,
  input  logic [N_WAYS-1:0]             reqValidWays,
  input  logic [N_WAYS-1:0]             reqLockedWays,
  output logic                          reqRdy,

  input  logic                          replRdy,
  output logic [$clog2(N_ENTRIES)-1:0]  replLookupIdx,
  output logic                          replLookupEn,
  input  logic [$clog2(N_WAYS)-1:0]     replLookupRsp,
  input  logic                          replLookupRspRdy,
  output logic [$clog2(N_ENTRIES)-1:0]  replRefIdx,
  output logic [N_WAYS-1:0]             replRefWayVec,
  output logic                          replRefEn,

  output logic                          victimValid,
  output logic [$clog2(N_WAYS)-1:0]     victimWay,
  output logic [N_WAYS-1:0]             victimWayVec,
  output logic                          victimEvict,
  output logic                          victimNone,
  input  logic                          victimDeq
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int WAY_W = $clog2(N_WAYS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT,
    S_OUT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [IDX_W-1:0]    r_idx;
  logic [N_WAYS-1:0]   r_elig;
  logic [WAY_W-1:0]    r_way;
  logic [N_WAYS-1:0]   r_vec;
  logic                r_evict;
  logic                r_none;
  logic                r_ref_pend;

  logic                w_accept;
  logic [N_WAYS-1:0]   w_elig_in;
  logic [N_WAYS-1:0]   w_free;
  logic [WAY_W-1:0]    w_free_way;
  logic [WAY_W-1:0]    w_rot_way;
  logic [WAY_W-1:0]    w_cand;

  logic                w_load;
  logic [WAY_W-1:0]    w_way_next;
  logic [N_WAYS-1:0]   w_vec_next;
  logic                w_evict_next;
  logic                w_none_next;

  assign reqRdy    = (r_state == S_IDLE) && replRdy && !reset;
  assign w_accept  = reqValid && reqRdy;
  assign w_elig_in = ~reqLockedWays;
  assign w_free    = w_elig_in & ~reqValidWays;

  // Lowest-numbered eligible empty way
  always_comb begin
    w_free_way = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (w_free[i]) w_free_way = WAY_W'(i);
    end
  end

  // First eligible way at or after the policy's choice, wrapping around
  always_comb begin
    w_rot_way = replLookupRsp;
    w_cand    = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      w_cand = replLookupRsp + WAY_W'(i);
      if (r_elig[w_cand]) w_rot_way = w_cand;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_way_next   = '0;
    w_evict_next = 1'b0;
    w_none_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (|w_free) begin
            w_state_next = S_OUT;
            w_load       = 1'b1;
            w_way_next   = w_free_way;
          end else if (!(|w_elig_in)) begin
            w_state_next = S_OUT;
            w_load       = 1'b1;
            w_none_next  = 1'b1;
          end else begin
            w_state_next = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: w_state_next = S_WAIT;
      S_WAIT: begin
        if (replLookupRspRdy) begin
          w_state_next = S_OUT;
          w_load       = 1'b1;
          w_way_next   = w_rot_way;
          w_evict_next = 1'b1;
        end
      end
      S_OUT: begin
        if (victimDeq) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_vec
    assign w_vec_next[gi] = !w_none_next && (w_way_next == WAY_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_elig     <= '0;
      r_way      <= '0;
      r_vec      <= '0;
      r_evict    <= 1'b0;
      r_none     <= 1'b0;
      r_ref_pend <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ref_pend <= w_load && !w_none_next;
      if (w_accept) begin
        r_idx  <= reqIdx;
        r_elig <= w_elig_in;
      end
      if (w_load) begin
        r_way   <= w_way_next;
        r_vec   <= w_vec_next;
        r_evict <= w_evict_next;
        r_none  <= w_none_next;
      end
    end
  end

  assign replLookupIdx = r_idx;
  assign replLookupEn  = (r_state == S_LOOKUP) && !reset;
  assign replRefIdx    = r_idx;
  assign replRefWayVec = r_vec;
  assign replRefEn     = r_ref_pend && !reset;

  assign victimValid   = (r_state == S_OUT) && !reset;
  assign victimWay     = r_way;
  assign victimWayVec  = r_vec;
  assign victimEvict   = r_evict;
  assign victimNone    = r_none;

endmodule

// File: tb/tb_cci_mpf_prim_victim_select.sv
// Directed and randomized checks of victim selection against a rule-level
// reference model; a monitor also watches lookup/reference exclusivity.
module tb_cci_mpf_prim_victim_select;

  localparam int NW = 4;
  localparam int NE = 64;
  localparam int IW = 6;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqValid;
  logic [IW-1:0] reqIdx;
  logic [NW-1:0] reqValidWays;
  logic [NW-1:0] reqLockedWays;
  logic          reqRdy;
  logic          replRdy;
  logic [IW-1:0] replLookupIdx;
  logic          replLookupEn;
  logic [WW-1:0] replLookupRsp;
  logic          replLookupRspRdy;
  logic [IW-1:0] replRefIdx;
  logic [NW-1:0] replRefWayVec;
  logic          replRefEn;
  logic          victimValid;
  logic [WW-1:0] victimWay;
  logic [NW-1:0] victimWayVec;
  logic          victimEvict;
  logic          victimNone;
  logic          victimDeq;

  int checks   = 0;
  int failures = 0;

  cci_mpf_prim_victim_select #(.N_WAYS(NW), .N_ENTRIES(NE)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqIdx(reqIdx), .reqValidWays(reqValidWays),
    .reqLockedWays(reqLockedWays), .reqRdy(reqRdy),
    .replRdy(replRdy), .replLookupIdx(replLookupIdx), .replLookupEn(replLookupEn),
    .replLookupRsp(replLookupRsp), .replLookupRspRdy(replLookupRspRdy),
    .replRefIdx(replRefIdx), .replRefWayVec(replRefWayVec), .replRefEn(replRefEn),
    .victimValid(victimValid), .victimWay(victimWay), .victimWayVec(victimWayVec),
    .victimEvict(victimEvict), .victimNone(victimNone), .victimDeq(victimDeq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) chk("lookup_ref_exclusive", 32'(replLookupEn && replRefEn), 0);
  end

  task automatic do_reset();
    reset = 1'b1;
    reqValid = 1'b0;
    victimDeq = 1'b0;
    replLookupRspRdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // Entered and left just after a falling edge.
  task automatic do_req(input string tag, input logic [3:0] vw, input logic [3:0] lw,
                        input int p, input int lat, input int hold, input bit noise);
    logic [3:0]    elig, free, evec;
    logic [IW-1:0] idx;
    int  ew, ecyc, cyc, lk_cyc, n_lk, n_ref_pre, w;
    bit  exp_lk, exp_none, exp_evict, found, got;

    elig = ~lw;
    free = elig & ~vw;
    ew = 0; exp_lk = 0; exp_none = 0; exp_evict = 0; found = 0;
    if (free != 0) begin
      for (int k = 0; k < NW; k++)
        if (!found && free[k]) begin ew = k; found = 1; end
    end else if (elig == 0) begin
      exp_none = 1;
    end else begin
      exp_lk = 1;
      exp_evict = 1;
      for (int k = 0; k < NW; k++)
        if (!found && elig[(p + k) % NW]) begin ew = (p + k) % NW; found = 1; end
    end
    evec = exp_none ? 4'b0000 : (4'b0001 << ew);
    ecyc = exp_lk ? 2 + lat : 1;

    w = 0;
    while (!reqRdy && w < 20) begin @(negedge clk); w++; end
    chk({tag, "_rdy"}, 32'(reqRdy), 1);

    idx = IW'($urandom);
    reqIdx = idx;
    reqValidWays = vw;
    reqLockedWays = lw;
    reqValid = 1'b1;
    replLookupRspRdy = noise ? 1'($urandom) : 1'b0;
    replLookupRsp = WW'($urandom);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqIdx = IW'($urandom);
    reqValidWays = NW'($urandom);
    reqLockedWays = NW'($urandom);

    cyc = 0; lk_cyc = -1; n_lk = 0; n_ref_pre = 0; got = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (replLookupEn) begin
        n_lk++;
        if (lk_cyc < 0) lk_cyc = cyc;
      end
      if (victimValid) got = 1;
      else if (replRefEn) n_ref_pre++;
      if (exp_lk && lk_cyc > 0 && cyc == lk_cyc + lat) begin
        replLookupRspRdy = 1'b1;
        replLookupRsp = WW'(p);
      end else if (noise && (!exp_lk || got)) begin
        replLookupRspRdy = 1'($urandom);
        replLookupRsp = WW'($urandom);
      end else begin
        replLookupRspRdy = 1'b0;
      end
      victimDeq = (noise && !got) ? 1'($urandom) : 1'b0;
    end

    chk({tag, "_got_victim"}, 32'(got), 1);
    if (!got) begin
      do_reset();
      return;
    end
    chk({tag, "_latency"}, cyc, ecyc);
    chk({tag, "_way"}, 32'(victimWay), ew);
    chk({tag, "_vec"}, 32'(victimWayVec), 32'(evec));
    chk({tag, "_evict"}, 32'(victimEvict), 32'(exp_evict));
    chk({tag, "_none"}, 32'(victimNone), 32'(exp_none));
    chk({tag, "_lookup_count"}, n_lk, 32'(exp_lk));
    if (exp_lk) begin
      chk({tag, "_lookup_cycle"}, lk_cyc, 1);
      chk({tag, "_lookup_idx"}, 32'(replLookupIdx), 32'(idx));
    end
    chk({tag, "_ref_early"}, n_ref_pre, 0);
    chk({tag, "_ref_en"}, 32'(replRefEn), 32'(!exp_none));
    if (!exp_none) begin
      chk({tag, "_ref_vec"}, 32'(replRefWayVec), 32'(evec));
      chk({tag, "_ref_idx"}, 32'(replRefIdx), 32'(idx));
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(victimValid), 1);
      chk({tag, "_hold_way"}, 32'(victimWay), ew);
      chk({tag, "_hold_vec"}, 32'(victimWayVec), 32'(evec));
      chk({tag, "_hold_evict"}, 32'(victimEvict), 32'(exp_evict));
      chk({tag, "_hold_none"}, 32'(victimNone), 32'(exp_none));
      chk({tag, "_hold_ref_en"}, 32'(replRefEn), 0);
      chk({tag, "_hold_rdy"}, 32'(reqRdy), 0);
      chk({tag, "_hold_lookup_en"}, 32'(replLookupEn), 0);
      replLookupRspRdy = noise ? 1'($urandom) : 1'b0;
    end

    victimDeq = 1'b1;
    @(negedge clk);
    victimDeq = 1'b0;
    replLookupRspRdy = 1'b0;
    chk({tag, "_deq_valid"}, 32'(victimValid), 0);
    chk({tag, "_deq_rdy"}, 32'(reqRdy), 1);
  endtask

  initial begin
    reset = 1'b1;
    reqValid = 1'b0;
    reqIdx = '0;
    reqValidWays = '0;
    reqLockedWays = '0;
    replRdy = 1'b1;
    replLookupRsp = '0;
    replLookupRspRdy = 1'b0;
    victimDeq = 1'b0;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_reqRdy", 32'(reqRdy), 0);
    chk("rst_victimValid", 32'(victimValid), 0);
    chk("rst_victimNone", 32'(victimNone), 0);
    chk("rst_victimEvict", 32'(victimEvict), 0);
    chk("rst_victimWay", 32'(victimWay), 0);
    chk("rst_victimWayVec", 32'(victimWayVec), 0);
    chk("rst_lookupEn", 32'(replLookupEn), 0);
    chk("rst_refEn", 32'(replRefEn), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_reqRdy", 32'(reqRdy), 1);

    // Request held off while the policy is not ready
    replRdy = 1'b0;
    #1;
    chk("replrdy_low_reqRdy", 32'(reqRdy), 0);
    reqValid = 1'b1;
    reqLockedWays = 4'b0000;
    reqValidWays = 4'b1111;
    @(negedge clk);
    chk("replrdy_low_no_out", 32'(victimValid), 0);
    chk("replrdy_low_no_lookup", 32'(replLookupEn), 0);
    reqValid = 1'b0;
    replRdy = 1'b1;
    @(negedge clk);
    chk("replrdy_low_still_idle", 32'(victimValid | replLookupEn), 0);

    do_req("free_1011", 4'b1011, 4'b0000, 0, 1, 0, 0);
    do_req("lookup_p3", 4'b1111, 4'b0000, 3, 1, 0, 0);
    do_req("wrap_p3", 4'b1111, 4'b1000, 3, 1, 0, 0);
    do_req("all_locked", 4'b0101, 4'b1111, 0, 1, 0, 0);
    do_req("hold5", 4'b1111, 4'b0011, 1, 1, 5, 0);
    do_req("slow_policy", 4'b1111, 4'b0110, 1, 3, 2, 0);
    do_req("free_locked_low", 4'b1100, 4'b0001, 0, 1, 1, 0);

    // Reset while waiting on the policy discards the request
    reqIdx = 6'd17;
    reqValidWays = 4'b1111;
    reqLockedWays = 4'b0000;
    reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    chk("abort_lookup_en", 32'(replLookupEn), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_rst_rdy", 32'(reqRdy), 0);
    chk("abort_in_rst_valid", 32'(victimValid), 0);
    chk("abort_in_rst_lookup", 32'(replLookupEn), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    replLookupRspRdy = 1'b1;
    replLookupRsp = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_victim", 32'(victimValid), 0);
      chk("abort_no_ref", 32'(replRefEn), 0);
      chk("abort_idle_rdy", 32'(reqRdy), 1);
    end
    replLookupRspRdy = 1'b0;

    for (int t = 0; t < 60; t++) begin
      logic [3:0] vw, lw;
      vw = 4'($urandom);
      if ($urandom_range(0, 3) == 0) lw = 4'b0000;
      else if ($urandom_range(0, 7) == 0) lw = 4'b1111;
      else lw = 4'($urandom);
      do_req("rand", vw, lw, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 3)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cci_mpf_prim_victim_select.md
CCI_MPF_PRIM_VICTIM_SELECT -- requirements
Module: cci_mpf_prim_victim_select

Interface
REQ-001 SHALL have parameter N_WAYS, default 4: associativity; power of 2, at least 2.
REQ-002 SHALL have parameter N_ENTRIES, default 1024: number of sets; power of 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have request ports, all inputs unless noted:
- reqValid, 1 bit
- reqIdx, $clog2(N_ENTRIES) bits: set index
- reqValidWays, N_WAYS bits: ways holding valid data
- reqLockedWays, N_WAYS bits: ways ineligible for replacement
- reqRdy, output, 1 bit
REQ-006 SHALL have replacement-policy ports:
- replRdy, input, 1 bit
- replLookupIdx, output, $clog2(N_ENTRIES) bits
- replLookupEn, output, 1 bit
- replLookupRsp, input, $clog2(N_WAYS) bits: policy way
- replLookupRspRdy, input, 1 bit
- replRefIdx, output, $clog2(N_ENTRIES) bits
- replRefWayVec, output, N_WAYS bits
- replRefEn, output, 1 bit
REQ-007 SHALL have result ports:
- victimValid, output, 1 bit
- victimWay, output, $clog2(N_WAYS) bits
- victimWayVec, output, N_WAYS bits: one-hot, or zero
- victimEvict, output, 1 bit: chosen way held valid data
- victimNone, output, 1 bit: no eligible way
- victimDeq, input, 1 bit

Function
REQ-008 SHALL implement FSM states IDLE, LOOKUP, WAIT, OUT; only one request in flight.
REQ-009 reqRdy SHALL equal (state==IDLE) && replRdy; a request is accepted when reqValid && reqRdy, and reqIdx, the eligible mask (~reqLockedWays) and reqValidWays are captured.
REQ-010 Accepted request where eligible & ~valid is non-zero SHALL go IDLE->OUT without a policy lookup: victim = lowest-numbered eligible invalid way, victimEvict=0, victimValid high one cycle after acceptance (N+1).
REQ-011 Accepted request where eligible is zero SHALL go IDLE->OUT without lookup: victimNone=1, victimWayVec=0, victimWay=0, victimEvict=0, victimValid at N+1.
REQ-012 Otherwise the FSM SHALL go IDLE->LOOKUP; in LOOKUP, replLookupEn=1 for exactly one cycle (N+1) with replLookupIdx=captured index; then WAIT.
REQ-013 In WAIT the FSM SHALL remain until replLookupRspRdy; on that cycle P=replLookupRsp is used and the FSM goes to OUT, victimValid high the following cycle (N+3 with single-cycle policy).
REQ-014 With policy way P: victim SHALL be P if eligible, else the first eligible way scanning P+1, P+2, ... modulo N_WAYS (wrap-around); victimEvict=1.
REQ-015 In OUT, result outputs SHALL be registered and held stable until victimDeq; victimDeq while victimValid SHALL return the FSM to IDLE next cycle; victimDeq outside OUT SHALL be ignored.
REQ-016 replRefEn SHALL pulse for exactly the first cycle of OUT when victimNone=0, with replRefIdx=captured index and replRefWayVec=victimWayVec; it SHALL be 0 when victimNone=1.
REQ-017 replLookupRspRdy outside WAIT SHALL be ignored.
REQ-018 replLookupEn and replRefEn SHALL never be asserted in the same cycle.

Reset
REQ-019 While reset is high: state=IDLE, reqRdy=0, victimValid=0, victimNone=0, victimEvict=0, replLookupEn=0, replRefEn=0; victimWay/victimWayVec=0.
REQ-020 Reset in any state SHALL abort the in-flight request; a replLookupRspRdy arriving after reset deasserts SHALL be ignored and produce no result.

Verification (N_WAYS=4)
REQ-021 valid=1011, locked=0000 accepted at N -> at N+1: victimWay=2, vec=0100, evict=0; replLookupEn never high; replRefEn high at N+1 with vec 0100.
REQ-022 valid=1111, locked=0000, replLookupRsp=3 -> replLookupEn high only at N+1; victimValid at N+3: way=3, vec=1000, evict=1.
REQ-023 valid=1111, locked=1000, replLookupRsp=3 -> victimWay=0 by wrap, vec=0001, evict=1.
REQ-024 locked=1111 -> at N+1: victimNone=1, vec=0000; no replLookupEn, no replRefEn.
REQ-025 victimDeq held low 5 cycles in OUT -> outputs stable, reqRdy=0, replRefEn high only the first cycle; deq -> reqRdy=1 next cycle if replRdy.
REQ-026 reset asserted in WAIT, then replLookupRspRdy=1 after release -> victimValid stays 0, FSM in IDLE.
